fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-side scheduler that shares the single write port of the BFM's `sync_fifo` among `NUM_REQ` requesters. Each requester asks for a burst of a declared length. A burst is granted only when the whole burst is guaranteed to fit. The granted requester then streams its beats into the FIFO with a valid/ready handshake until the burst completes. The block tracks FIFO occupancy itself, so admission control never relies on the FIFO's own counter.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `WIDTH`, 128: data width; matches the FIFO `WIDTH`.
- `DEPTH`, 4096: FIFO depth; matches the FIFO `DEPTH`.
- `MAX_BURST`, 16: maximum legal burst length in beats.
- `LEN_W`, localparam $clog2(MAX_BURST+1): burst-length field width.
- `LVL_W`, localparam $clog2(DEPTH)+1: occupancy width.

- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: per-requester beat-valid / burst request.
- `req_len` in NUM_REQ*LEN_W: burst length; slice i belongs to requester i; sampled at arbitration.
- `req_data` in NUM_REQ*WIDTH: beat data; slice i belongs to requester i.
- `req_ready` out NUM_REQ: beat accepted when `req_valid[i] && req_ready[i]`.
- `grant` out NUM_REQ: one-hot current owner; all-zero when idle.
- `fifo_wr_en` out 1: FIFO write strobe.
- `fifo_wr_data` out WIDTH: FIFO write data.
- `fifo_full` in 1: FIFO full flag.
- `fifo_rd_en` in 1: FIFO read strobe; monitored for occupancy.
- `level` out LVL_W: tracked FIFO occupancy.
- `busy` out 1: high in BURST.
- `protocol_err` out 1: sticky illegal-length flag.

## Operation
- FSM states: IDLE, BURST.
- **Eligibility in IDLE.** Requester i is eligible when all of the following hold:
  - `req_valid[i]` is high;
  - `1 <= req_len[i] <= MAX_BURST`;
  - `level + req_len[i] <= DEPTH`.
- **Illegal length.** `req_valid[i]` with `req_len[i]==0` or `req_len[i] > MAX_BURST`:
  - the requester is never granted;
  - `protocol_err` is set and stays high until reset.
- **IDLE → BURST.** When any requester is eligible:
  - pick the first eligible index after `last_ptr`, round-robin and wrapping;
  - register `grant`, load `beats = req_len`, go to BURST.
- **BURST handshake.**
  - `req_ready[g] = !fifo_full`; all other `req_ready` bits are 0.
  - On an accepted beat: `fifo_wr_en=1`, `fifo_wr_data=req_data[g]` (combinational mux), `beats` decrements.
  - If `req_valid[g]` drops, the burst stalls indefinitely. `grant` is held and no writes occur.
- **BURST → IDLE.** Taken on acceptance of the final beat (`beats==1`). `last_ptr` is set to g and `grant` clears on the next cycle.
- **Occupancy.**
  - `level` increments on `fifo_wr_en`.
  - `level` decrements on `fifo_rd_en && level!=0`.
  - When both occur in the same cycle, `level` is unchanged.
  - `fifo_rd_en` at `level==0` is ignored.
- **Arithmetic widths.**
  - The fit check is computed at LVL_W+1 bits; no overflow is allowed.
  - `beats` is LEN_W bits.
- **Admission guarantee.** The fit check makes `fifo_full` unreachable during a granted burst, because reads only lower `level`. The `fifo_full` gating of `req_ready` remains as a safety interlock.

## Timing
- **Reset values.** While `rst` is low, asynchronously:
  - `grant`, `req_ready`, `fifo_wr_en`, `level`, `busy`, `protocol_err` are 0;
  - `fifo_wr_data` is 0;
  - state is IDLE;
  - `last_ptr` is NUM_REQ-1, so requester 0 has first priority.
- **Grant latency.** A request eligible in cycle N produces `grant`/`busy` in cycle N+1. The first beat can be accepted in cycle N+1.
- **Burst throughput.** One beat per cycle while valid and not full.
- **Burst turnaround.** Last beat accepted in cycle M gives IDLE in M+1 and the next grant at M+2, earliest. This is a one-cycle bubble.
- **Reset mid-burst.** The burst is abandoned with no further writes. `level` resets to 0, matching the FIFO's shared reset.

## Structure
- **Package `fifo_arb_pkg`:**
  - state enum (IDLE, BURST);
  - helper localparams for the LEN_W / LVL_W derivation.
- **Sub-module `rr_pick`:** combinational round-robin selector. Inputs are an eligible mask and `last_ptr`; outputs are a one-hot winner and a found flag.
- The top level holds the FSM, beat counter, occupancy counter and data mux.

## Test plan
- **Single burst.** Requester 1, `req_len=4`, always valid, no reads → `grant=4'b0010` one cycle later; 4 consecutive `fifo_wr_en` beats with correct data; `level=4`; back to IDLE.
- **Round-robin order.** All 4 requesters with `req_len=2` right after reset → grants in order 0,1,2,3; each burst 2 beats; 1-cycle gap between bursts; final `level=8`.
- **Admission control.** `DEPTH=8`, `level=6`, requester 0 `req_len=4` → no grant. Issue 2 `fifo_rd_en` pulses → `level=4` → grant next cycle; final `level=8` with `fifo_full` never asserted during the burst.
- **Mid-burst stall.** `req_valid` drops for 3 cycles mid-burst → `grant` held, `fifo_wr_en=0`, `beats` frozen; the burst resumes and completes.
- **Occupancy edge cases.**
  - Simultaneous write and `fifo_rd_en` → `level` unchanged.
  - `fifo_rd_en` at `level=0` → `level` stays 0.
  - `req_len=0` or 17 → never granted, `protocol_err=1` sticky.
- **Reset mid-burst.** Assert `rst` mid-burst → all outputs 0 immediately. After release, requesters 2 and 0 both valid → requester 0 granted first.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg: shared state type and width helpers for fifo_wr_arbiter
package fifo_arb_pkg;
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;
  function automatic int len_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic int ptr_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester burst bus plus shared FIFO write port
interface fifo_wr_arbiter_if import fifo_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 128,
  parameter int MAX_BURST = 16
);
  localparam int LEN_W = len_w(MAX_BURST);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] grant;
  logic fifo_wr_en;
  logic [WIDTH-1:0] fifo_wr_data;
  logic fifo_full;
  logic fifo_rd_en;
  modport master (
    input req_valid, req_len, req_data, fifo_full, fifo_rd_en,
    output req_ready, grant, fifo_wr_en, fifo_wr_data
  );
  modport slave (
    output req_valid, req_len, req_data, fifo_full, fifo_rd_en,
    input req_ready, grant, fifo_wr_en, fifo_wr_data
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: one-hot round-robin winner, searching upward from the slot after last_ptr
module rr_pick import fifo_arb_pkg::*; #(
  parameter int N = 4,
  localparam int PW = ptr_w(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] last_ptr,
  output logic [N-1:0]  win,
  output logic          found
);
  int idx;
  always_comb begin
    win = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_ptr) + k) % N;
      if (!found && elig[idx]) begin
        win[idx] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst scheduler for a shared FIFO write port
// with its own occupancy tracking so a burst is only granted when it fits.
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 128,
  parameter int DEPTH = 4096,
  parameter int MAX_BURST = 16,
  localparam int LEN_W = len_w(MAX_BURST),
  localparam int LVL_W = lvl_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  fifo_wr_arbiter_if.master bus,
  output logic [LVL_W-1:0] level,
  output logic             busy,
  output logic             protocol_err
);
  localparam int PTR_W = ptr_w(NUM_REQ);
  localparam int FIT_W = (LVL_W > LEN_W ? LVL_W : LEN_W) + 1;
  state_e state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, elig, win, ready;
  logic [LEN_W-1:0] beats_q, beats_d;
  logic [PTR_W-1:0] last_q, last_d, gidx, widx;
  logic [LVL_W-1:0] level_q, level_d;
  logic perr_q, perr_d, found, wr_en, done, rd_ok, bad;
  logic [LEN_W-1:0] len [NUM_REQ];
  logic [WIDTH-1:0] wr_data;
  // the fit check is widened one bit past both operands so it cannot wrap
  always_comb begin
    elig = '0;
    bad = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      len[i] = bus.req_len[i*LEN_W +: LEN_W];
      elig[i] = state_q == IDLE && bus.req_valid[i] && len[i] != '0 &&
                len[i] <= LEN_W'(MAX_BURST) &&
                FIT_W'(level_q) + FIT_W'(len[i]) <= FIT_W'(DEPTH);
      bad = bad | (bus.req_valid[i] && (len[i] == '0 || len[i] > LEN_W'(MAX_BURST)));
    end
  end
  rr_pick #(.N(NUM_REQ)) u_pick (
    .elig     (elig),
    .last_ptr (last_q),
    .win      (win),
    .found    (found)
  );
  always_comb begin
    gidx = '0;
    widx = '0;
    wr_data = '0;
    ready = (state_q == BURST && !bus.fifo_full) ? grant_q : '0;
    wr_en = |(ready & bus.req_valid);
    for (int i = 0; i < NUM_REQ; i++) begin
      gidx = grant_q[i] ? PTR_W'(i) : gidx;
      widx = win[i] ? PTR_W'(i) : widx;
      wr_data = wr_data | (bus.req_data[i*WIDTH +: WIDTH] & {WIDTH{wr_en && grant_q[i]}});
    end
    done = wr_en && beats_q == LEN_W'(1);
    rd_ok = bus.fifo_rd_en && level_q != '0;
    state_d = state_q == IDLE ? (found ? BURST : IDLE) : (done ? IDLE : BURST);
    grant_d = state_q == IDLE ? win : (done ? '0 : grant_q);
    beats_d = state_q == IDLE ? (found ? len[widx] : beats_q) : beats_q - LEN_W'(wr_en);
    last_d = done ? gidx : last_q;
    level_d = level_q + LVL_W'(wr_en) - LVL_W'(rd_ok);
    perr_d = perr_q | bad;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      beats_q <= '0;
      last_q <= PTR_W'(NUM_REQ - 1);
      level_q <= '0;
      perr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      beats_q <= beats_d;
      last_q <= last_d;
      level_q <= level_d;
      perr_q <= perr_d;
    end
  end
  assign bus.grant = grant_q;
  assign bus.req_ready = ready;
  assign bus.fifo_wr_en = wr_en;
  assign bus.fifo_wr_data = wr_data;
  assign level = level_q;
  assign busy = state_q == BURST;
  assign protocol_err = perr_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: randomized scenarios checked against a transaction-level arbiter model
module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int D = 8;
  localparam int MB = 16;
  localparam int LW = 5;
  localparam int LVW = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  fifo_wr_arbiter_if #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) bus ();
  logic [LVW-1:0] level;
  logic busy, perr;
  fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .DEPTH(D), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .level        (level),
    .busy         (busy),
    .protocol_err (perr)
  );
  int n_chk = 0;
  int n_fail = 0;
  logic v [N];
  int ln [N];
  logic [W-1:0] dt [N];
  logic oneshot [N];
  logic rd, ffull;
  int m_own, m_beats, m_last, m_level;
  bit m_perr;
  int cyc = 0;
  int obs_wr = 0;
  int gl [$];
  int gc [$];
  logic [N-1:0] prev_g = '0;
  bit full_in_burst = 0;

  task automatic model_reset();
    m_own = -1;
    m_beats = 0;
    m_last = N - 1;
    m_level = 0;
    m_perr = 0;
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = v[i];
      bus.req_len[i*LW +: LW] = LW'(ln[i]);
      bus.req_data[i*W +: W] = dt[i];
    end
    bus.fifo_rd_en = rd;
    bus.fifo_full = ffull || (m_level >= D);
  endtask

  task automatic fail_line(input string name, input logic [63:0] got, input logic [63:0] want);
    n_fail++;
    $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
  endtask

  // one clock: predict this cycle's outputs, compare, then advance the model at the edge
  task automatic step();
    logic [N-1:0] eg, er;
    logic ew, full, found;
    int fin, lvl, idx;
    for (int i = 0; i < N; i++) dt[i] = $urandom;
    apply();
    #1;
    full = bus.fifo_full;
    eg = '0;
    if (m_own >= 0) eg[m_own] = 1'b1;
    er = (m_own >= 0 && !full) ? eg : '0;
    ew = m_own >= 0 && v[m_own] && !full;
    n_chk++; if (bus.grant !== eg) fail_line("grant", 64'(bus.grant), 64'(eg));
    n_chk++; if (bus.req_ready !== er) fail_line("req_ready", 64'(bus.req_ready), 64'(er));
    n_chk++; if (bus.fifo_wr_en !== ew) fail_line("fifo_wr_en", 64'(bus.fifo_wr_en), 64'(ew));
    if (ew) begin
      n_chk++; if (bus.fifo_wr_data !== dt[m_own]) fail_line("fifo_wr_data", 64'(bus.fifo_wr_data), 64'(dt[m_own]));
    end
    n_chk++; if (level !== LVW'(m_level)) fail_line("level", 64'(level), 64'(m_level));
    n_chk++; if (busy !== (m_own >= 0)) fail_line("busy", 64'(busy), 64'(m_own >= 0));
    n_chk++; if (perr !== m_perr) fail_line("protocol_err", 64'(perr), 64'(m_perr));
    if (bus.grant !== '0 && prev_g === '0) begin
      for (int i = 0; i < N; i++) if (bus.grant[i] === 1'b1) gl.push_back(i);
      gc.push_back(cyc);
    end
    prev_g = bus.grant;
    if (bus.fifo_wr_en === 1'b1) obs_wr++;
    if (m_own >= 0 && full) full_in_burst = 1;
    @(posedge clk);
    fin = -1;
    lvl = m_level;
    for (int i = 0; i < N; i++) if (v[i] && (ln[i] == 0 || ln[i] > MB)) m_perr = 1;
    if (m_own < 0) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (!found && v[idx] && ln[idx] >= 1 && ln[idx] <= MB && lvl + ln[idx] <= D) begin
          found = 1;
          m_own = idx;
          m_beats = ln[idx];
        end
      end
    end else if (ew) begin
      m_beats--;
      if (m_beats == 0) begin
        m_last = m_own;
        fin = m_own;
        m_own = -1;
      end
    end
    m_level = lvl + (ew ? 1 : 0) - ((rd && lvl > 0) ? 1 : 0);
    cyc++;
    @(negedge clk);
    if (fin >= 0 && oneshot[fin]) v[fin] = 1'b0;
  endtask

  task automatic run_idle(input int bound);
    int n;
    bit pending;
    n = 0;
    pending = 1;
    while (pending && n < bound) begin
      step();
      n++;
      pending = m_own >= 0;
      for (int i = 0; i < N; i++) pending = pending | v[i];
    end
    if (pending) begin
      n_chk++;
      n_fail++;
      $display("FAIL run_idle timeout after %0d cycles", bound);
    end
  endtask

  task automatic drain();
    int n;
    for (int i = 0; i < N; i++) v[i] = 1'b0;
    rd = 1'b1;
    n = 0;
    while (m_level != 0 && n < 20) begin
      step();
      n++;
    end
    rd = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_chk++; if (bus.grant !== 4'b0000) fail_line("rst grant", 64'(bus.grant), 0);
    n_chk++; if (bus.req_ready !== 4'b0000) fail_line("rst req_ready", 64'(bus.req_ready), 0);
    n_chk++; if (bus.fifo_wr_en !== 1'b0) fail_line("rst fifo_wr_en", 64'(bus.fifo_wr_en), 0);
    n_chk++; if (bus.fifo_wr_data !== 32'h0) fail_line("rst fifo_wr_data", 64'(bus.fifo_wr_data), 0);
    n_chk++; if (level !== 4'd0) fail_line("rst level", 64'(level), 0);
    n_chk++; if (busy !== 1'b0 || perr !== 1'b0) fail_line("rst busy/perr", 64'({busy, perr}), 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_round_robin();
    gl.delete();
    gc.delete();
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b1;
      ln[i] = 2;
    end
    run_idle(40);
    n_chk++; if (gl.size() != 4) fail_line("rr grant count", 64'(gl.size()), 4);
    for (int k = 0; k < 4 && k < gl.size(); k++) begin
      n_chk++; if (gl[k] != k) fail_line("rr order", 64'(gl[k]), 64'(k));
    end
    for (int k = 0; k + 1 < gc.size(); k++) begin
      n_chk++; if (gc[k+1] - gc[k] != 3) fail_line("rr spacing", 64'(gc[k+1] - gc[k]), 3);
    end
    n_chk++; if (level !== 4'd8) fail_line("rr level", 64'(level), 8);
    drain();
  endtask

  task automatic test_single();
    int w0;
    w0 = obs_wr;
    v[1] = 1'b1;
    ln[1] = 4;
    step();
    n_chk++; if (bus.grant !== 4'b0010) fail_line("single grant", 64'(bus.grant), 2);
    run_idle(20);
    n_chk++; if (obs_wr - w0 != 4) fail_line("single beats", 64'(obs_wr - w0), 4);
    n_chk++; if (level !== 4'd4) fail_line("single level", 64'(level), 4);
    n_chk++; if (busy !== 1'b0) fail_line("single idle", 64'(busy), 0);
    drain();
  endtask

  task automatic test_admission();
    v[2] = 1'b1;
    ln[2] = 6;
    run_idle(20);
    n_chk++; if (level !== 4'd6) fail_line("adm prefill", 64'(level), 6);
    gl.delete();
    full_in_burst = 0;
    v[0] = 1'b1;
    ln[0] = 4;
    repeat (4) begin
      step();
      n_chk++; if (bus.grant !== 4'b0000) fail_line("adm blocked", 64'(bus.grant), 0);
    end
    rd = 1'b1;
    repeat (2) step();
    rd = 1'b0;
    n_chk++; if (level !== 4'd4) fail_line("adm drained", 64'(level), 4);
    run_idle(20);
    n_chk++; if (gl.size() != 1 || gl[0] != 0) fail_line("adm winner", 64'(gl.size() > 0 ? gl[0] : -1), 0);
    n_chk++; if (level !== 4'd8) fail_line("adm level", 64'(level), 8);
    n_chk++; if (full_in_burst) fail_line("adm full in burst", 1, 0);
    drain();
  endtask

  task automatic test_stall();
    int w0;
    w0 = obs_wr;
    v[3] = 1'b1;
    ln[3] = 6;
    repeat (3) step();
    v[3] = 1'b0;
    repeat (3) begin
      apply();
      #1;
      n_chk++; if (bus.grant !== 4'b1000) fail_line("stall grant", 64'(bus.grant), 8);
      n_chk++; if (bus.fifo_wr_en !== 1'b0) fail_line("stall wr_en", 64'(bus.fifo_wr_en), 0);
      step();
    end
    n_chk++; if (level !== 4'd2) fail_line("stall level", 64'(level), 2);
    v[3] = 1'b1;
    run_idle(20);
    n_chk++; if (obs_wr - w0 != 6) fail_line("stall beats", 64'(obs_wr - w0), 6);
    n_chk++; if (level !== 4'd6) fail_line("stall final level", 64'(level), 6);
    drain();
  endtask

  task automatic test_occupancy();
    int n;
    v[1] = 1'b1;
    ln[1] = 2;
    run_idle(20);
    v[2] = 1'b1;
    ln[2] = 3;
    n = 0;
    while ((v[2] || m_own >= 0) && n < 20) begin
      rd = m_own >= 0;
      step();
      n++;
    end
    rd = 1'b0;
    n_chk++; if (level !== 4'd2) fail_line("occ wr+rd level", 64'(level), 2);
    drain();
    rd = 1'b1;
    repeat (2) step();
    rd = 1'b0;
    n_chk++; if (level !== 4'd0) fail_line("occ rd at empty", 64'(level), 0);
  endtask

  task automatic test_random();
    int w0;
    w0 = obs_wr;
    for (int i = 0; i < N; i++) oneshot[i] = 1'b0;
    repeat (300) begin
      for (int i = 0; i < N; i++) begin
        v[i] = ($urandom % 4) != 0;
        ln[i] = 1 + int'($urandom % 8);
      end
      rd = ($urandom % 3) == 0;
      ffull = ($urandom % 8) == 0;
      step();
    end
    ffull = 1'b0;
    rd = 1'b0;
    for (int i = 0; i < N; i++) begin
      oneshot[i] = 1'b1;
      v[i] = m_own == i;
    end
    run_idle(30);
    n_chk++; if (obs_wr - w0 < 20) fail_line("random too few writes", 64'(obs_wr - w0), 20);
    drain();
  endtask

  task automatic test_illegal();
    v[0] = 1'b1;
    ln[0] = 0;
    step();
    n_chk++; if (perr !== 1'b1) fail_line("illegal len0 perr", 64'(perr), 1);
    repeat (3) begin
      step();
      n_chk++; if (bus.grant !== 4'b0000) fail_line("illegal len0 grant", 64'(bus.grant), 0);
    end
    v[0] = 1'b0;
    v[1] = 1'b1;
    ln[1] = 17;
    repeat (3) begin
      step();
      n_chk++; if (bus.grant !== 4'b0000) fail_line("illegal len17 grant", 64'(bus.grant), 0);
    end
    v[1] = 1'b0;
    repeat (2) step();
    n_chk++; if (perr !== 1'b1) fail_line("illegal sticky", 64'(perr), 1);
  endtask

  task automatic test_reset_mid_burst();
    v[1] = 1'b1;
    ln[1] = 5;
    repeat (3) step();
    #3;
    rst = 1'b0;
    #1;
    n_chk++; if (bus.grant !== 4'b0000) fail_line("midrst grant", 64'(bus.grant), 0);
    n_chk++; if (bus.fifo_wr_en !== 1'b0 || bus.req_ready !== 4'b0000) fail_line("midrst wr/ready", 64'({bus.fifo_wr_en, bus.req_ready}), 0);
    n_chk++; if (level !== 4'd0) fail_line("midrst level", 64'(level), 0);
    n_chk++; if (busy !== 1'b0 || perr !== 1'b0) fail_line("midrst busy/perr", 64'({busy, perr}), 0);
    model_reset();
    for (int i = 0; i < N; i++) v[i] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    gl.delete();
    v[2] = 1'b1;
    ln[2] = 2;
    v[0] = 1'b1;
    ln[0] = 2;
    run_idle(20);
    n_chk++; if (gl.size() != 2) fail_line("midrst grants", 64'(gl.size()), 2);
    if (gl.size() == 2) begin
      n_chk++; if (gl[0] != 0 || gl[1] != 2) fail_line("midrst order", 64'({gl[0][7:0], gl[1][7:0]}), 64'h0002);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0;
      ln[i] = 1;
      dt[i] = '0;
      oneshot[i] = 1'b1;
    end
    rd = 1'b0;
    ffull = 1'b0;
    model_reset();
    apply();
    test_reset();
    test_round_robin();
    test_single();
    test_admission();
    test_stall();
    test_occupancy();
    test_random();
    test_illegal();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
